emif_rdwr_arbiter: RTL and testbench

//  Merges the line buffer's EMIF write master (capture-side burst writer) and EMIF read

---
 rtl/emif_rdwr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_emif_rdwr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emif_rdwr_arbiter.sv
// Read/write arbiter merging the line buffer's EMIF write and read masters onto one
// Avalon-MM burst port; reads win, bounded by a write-starvation guard and a read-beat cap.
module emif_rdwr_arbiter #(
  parameter int RD_MAX_OUTSTANDING = 64,
  parameter int WR_MAX_WAIT        = 256,
  parameter int MAXBURST           = 32
) (
  input  logic         emif_br_clk,
  input  logic         emif_br_reset,
  input  logic [27:0]  wr_addr,
  input  logic         wr_write,
  input  logic [255:0] wr_wdata,
  input  logic [5:0]   wr_burstcount,
  output logic         wr_waitrequest,
  input  logic [27:0]  rd_addr,
  input  logic         rd_read,
  input  logic [5:0]   rd_burstcount,
  output logic         rd_waitrequest,
  output logic [255:0] rd_rdata,
  output logic         rd_readdatavalid,
  output logic [27:0]  avl_addr,
  output logic         avl_read,
  output logic         avl_write,
  output logic [255:0] avl_wdata,
  output logic [5:0]   avl_burstcount,
  input  logic         avl_waitrequest,
  input  logic [255:0] avl_rdata,
  input  logic         avl_readdatavalid,
  output logic         err_spurious_rdv
);

  localparam int                WAIT_W   = $clog2(WR_MAX_WAIT + 2);
  localparam logic [8:0]        RD_CAP   = 9'(RD_MAX_OUTSTANDING);
  localparam logic [5:0]        BC_MAX   = 6'(MAXBURST);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(WR_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [8:0]        rd_outstanding;
  logic [8:0]        rd_outstanding_next;
  logic [8:0]        rd_sum;
  logic [8:0]        rd_add;
  logic [WAIT_W-1:0] wr_wait_ctr;
  logic [5:0]        wr_beats_left;
  logic              rd_ok;
  logic              wr_ok;
  logic              wr_starved;
  logic              wr_beat;
  logic              rd_accept;
  logic              rd_dec;
  logic              wr_enter;

  // Sum is 9 bits wide so outstanding + burstcount can never wrap past the cap.
  assign rd_sum     = rd_outstanding + {3'b000, rd_burstcount};
  assign rd_ok      = rd_read && (rd_burstcount != 6'd0) && (rd_burstcount <= BC_MAX) && (rd_sum <= RD_CAP);
  assign wr_ok      = wr_write && (wr_burstcount != 6'd0) && (wr_burstcount <= BC_MAX);
  assign wr_starved = (wr_wait_ctr >= WAIT_SAT);
  assign wr_beat    = wr_write && !avl_waitrequest;
  assign rd_accept  = (state == RD_CMD) && rd_read && !avl_waitrequest;
  assign rd_dec     = avl_readdatavalid && (rd_outstanding != 9'd0);
  assign wr_enter   = (state != WR_BURST) && (state_next == WR_BURST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wr_ok && wr_starved) begin
          state_next = WR_BURST;
        end else if (rd_ok) begin
          state_next = RD_CMD;
        end else if (wr_ok) begin
          state_next = WR_BURST;
        end else begin
          state_next = IDLE;
        end
      end
      WR_BURST: begin
        if (wr_beat && (wr_beats_left == 6'd1)) begin
          state_next = IDLE;
        end else begin
          state_next = WR_BURST;
        end
      end
      RD_CMD: begin
        if (!rd_read || !avl_waitrequest) begin
          state_next = IDLE;
        end else begin
          state_next = RD_CMD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    avl_addr       = 28'd0;
    avl_wdata      = 256'd0;
    avl_burstcount = 6'd0;
    avl_read       = 1'b0;
    avl_write      = 1'b0;
    wr_waitrequest = 1'b1;
    rd_waitrequest = 1'b1;
    case (state)
      WR_BURST: begin
        avl_addr       = wr_addr;
        avl_wdata      = wr_wdata;
        avl_burstcount = wr_burstcount;
        avl_write      = wr_write;
        wr_waitrequest = avl_waitrequest;
      end
      RD_CMD: begin
        avl_addr       = rd_addr;
        avl_burstcount = rd_burstcount;
        avl_read       = rd_read;
        rd_waitrequest = avl_waitrequest;
      end
      default: begin
        avl_read = 1'b0;
      end
    endcase
  end

  // Returns bypass the FSM entirely so they can overlap a write burst.
  assign rd_rdata         = avl_rdata;
  assign rd_readdatavalid = avl_readdatavalid;

  always_comb begin
    rd_add              = rd_accept ? {3'b000, rd_burstcount} : 9'd0;
    rd_outstanding_next = rd_outstanding + rd_add - {8'd0, rd_dec};
  end

  always_ff @(posedge emif_br_clk or posedge emif_br_reset) begin
    if (emif_br_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write-side bookkeeping: starvation age and remaining beats of the granted burst.
  always_ff @(posedge emif_br_clk or posedge emif_br_reset) begin
    if (emif_br_reset) begin
      wr_wait_ctr   <= '0;
      wr_beats_left <= 6'd0;
    end else if (wr_enter) begin
      wr_wait_ctr   <= '0;
      wr_beats_left <= wr_burstcount;
    end else begin
      if (wr_write && (state != WR_BURST) && (wr_wait_ctr < WAIT_SAT)) begin
        wr_wait_ctr <= wr_wait_ctr + WAIT_W'(1);
      end
      if ((state == WR_BURST) && wr_beat) begin
        wr_beats_left <= wr_beats_left - 6'd1;
      end
    end
  end

  always_ff @(posedge emif_br_clk or posedge emif_br_reset) begin
    if (emif_br_reset) begin
      rd_outstanding   <= 9'd0;
      err_spurious_rdv <= 1'b0;
    end else begin
      rd_outstanding <= rd_outstanding_next;
      if (avl_readdatavalid && (rd_outstanding == 9'd0)) begin
        err_spurious_rdv <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_emif_rdwr_arbiter.sv
// Self-checking bench for emif_rdwr_arbiter: grant table, directed corner sequences and a
// randomized run scored every cycle against a transaction-level model of the arbitration rules.
module tb_emif_rdwr_arbiter;

  localparam int RDMAX = 64;
  localparam int WRMAX = 256;
  localparam int MAXB  = 32;
  localparam int OWN_IDLE = 0;
  localparam int OWN_WR   = 1;
  localparam int OWN_RD   = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [27:0]  wr_addr;
  logic         wr_write;
  logic [255:0] wr_wdata;
  logic [5:0]   wr_burstcount;
  logic         wr_waitrequest;
  logic [27:0]  rd_addr;
  logic         rd_read;
  logic [5:0]   rd_burstcount;
  logic         rd_waitrequest;
  logic [255:0] rd_rdata;
  logic         rd_readdatavalid;
  logic [27:0]  avl_addr;
  logic         avl_read;
  logic         avl_write;
  logic [255:0] avl_wdata;
  logic [5:0]   avl_burstcount;
  logic         avl_waitrequest;
  logic [255:0] avl_rdata;
  logic         avl_readdatavalid;
  logic         err_spurious_rdv;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  emif_rdwr_arbiter #(.RD_MAX_OUTSTANDING(RDMAX), .WR_MAX_WAIT(WRMAX), .MAXBURST(MAXB)) dut (
    .emif_br_clk(clk), .emif_br_reset(rst),
    .wr_addr(wr_addr), .wr_write(wr_write), .wr_wdata(wr_wdata), .wr_burstcount(wr_burstcount),
    .wr_waitrequest(wr_waitrequest),
    .rd_addr(rd_addr), .rd_read(rd_read), .rd_burstcount(rd_burstcount),
    .rd_waitrequest(rd_waitrequest), .rd_rdata(rd_rdata), .rd_readdatavalid(rd_readdatavalid),
    .avl_addr(avl_addr), .avl_read(avl_read), .avl_write(avl_write), .avl_wdata(avl_wdata),
    .avl_burstcount(avl_burstcount), .avl_waitrequest(avl_waitrequest), .avl_rdata(avl_rdata),
    .avl_readdatavalid(avl_readdatavalid), .err_spurious_rdv(err_spurious_rdv)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    check(name, 256'(act), 256'(exp));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: who owns the port, beats left, read beats in flight, write age.
  int m_own = OWN_IDLE, m_left = 0, m_out = 0, m_wait = 0;
  bit m_err = 1'b0;
  int nxt, add, rbc, wbc;
  bit rd_ok, wr_ok;
  logic [27:0]  e_addr;
  logic [5:0]   e_bc;
  logic [255:0] e_wd;
  logic         e_rd, e_wr, e_wrw, e_rdw;

  always @(negedge clk) begin
    e_addr = 28'd0; e_bc = 6'd0; e_wd = 256'd0;
    e_rd = 1'b0; e_wr = 1'b0; e_wrw = 1'b1; e_rdw = 1'b1;
    if (!rst && m_own == OWN_WR) begin
      e_addr = wr_addr; e_bc = wr_burstcount; e_wd = wr_wdata; e_wr = wr_write; e_wrw = avl_waitrequest;
    end else if (!rst && m_own == OWN_RD) begin
      e_addr = rd_addr; e_bc = rd_burstcount; e_rd = rd_read; e_rdw = avl_waitrequest;
    end
    check("sb_ctrl",
          256'({avl_addr, avl_burstcount, avl_read, avl_write, wr_waitrequest, rd_waitrequest,
                rd_readdatavalid, err_spurious_rdv}),
          256'({e_addr, e_bc, e_rd, e_wr, e_wrw, e_rdw, avl_readdatavalid, (!rst && m_err)}));
    check("sb_wdata", avl_wdata, e_wd);
    check("sb_rdata", rd_rdata, avl_rdata);
    if (rst) begin
      m_own = OWN_IDLE; m_left = 0; m_out = 0; m_wait = 0; m_err = 1'b0;
    end else begin
      rbc = int'(rd_burstcount);
      wbc = int'(wr_burstcount);
      rd_ok = rd_read && rbc >= 1 && rbc <= MAXB && (m_out + rbc) <= RDMAX;
      wr_ok = wr_write && wbc >= 1 && wbc <= MAXB;
      nxt = m_own; add = 0;
      if (m_own == OWN_IDLE) begin
        if (wr_ok && m_wait >= WRMAX) nxt = OWN_WR;
        else if (rd_ok) nxt = OWN_RD;
        else if (wr_ok) nxt = OWN_WR;
      end else if (m_own == OWN_WR) begin
        if (wr_write && !avl_waitrequest) begin
          m_left--;
          if (m_left == 0) nxt = OWN_IDLE;
        end
      end else begin
        if (!rd_read) nxt = OWN_IDLE;
        else if (!avl_waitrequest) begin add = rbc; nxt = OWN_IDLE; end
      end
      if (m_own != OWN_WR && nxt == OWN_WR) begin
        m_wait = 0; m_left = wbc;
      end else if (m_own != OWN_WR && wr_write && m_wait < WRMAX) begin
        m_wait++;
      end
      if (avl_readdatavalid) begin
        if (m_out == 0) m_err = 1'b1;
        else m_out--;
      end
      m_out += add;
      m_own = nxt;
    end
  end

  task automatic to_neg(); @(negedge clk); #1; endtask
  task automatic to_pos(); @(posedge clk); #1; endtask

  task automatic idle_inputs();
    wr_addr = 28'h1000; wr_write = 1'b0; wr_wdata = 256'd0; wr_burstcount = 6'd0;
    rd_addr = 28'h2000; rd_read = 1'b0; rd_burstcount = 6'd0;
    avl_waitrequest = 1'b0; avl_rdata = 256'd0; avl_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    to_neg();
    to_pos();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         wr;
    logic [5:0] wbc;
    bit         rd;
    logic [5:0] rbc;
    bit         ex_rd;
    bit         ex_wr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 6'd4,  1'b0, 6'd0,  1'b0, 1'b1};
    tbl[1]  = '{1'b0, 6'd0,  1'b1, 6'd8,  1'b1, 1'b0};
    tbl[2]  = '{1'b1, 6'd4,  1'b1, 6'd8,  1'b1, 1'b0};
    tbl[3]  = '{1'b1, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 6'd0,  1'b1, 6'd0,  1'b0, 1'b0};
    tbl[5]  = '{1'b0, 6'd0,  1'b1, 6'd33, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 6'd40, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[7]  = '{1'b1, 6'd4,  1'b1, 6'd0,  1'b0, 1'b1};
    tbl[8]  = '{1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0};
    tbl[9]  = '{1'b0, 6'd0,  1'b1, 6'd32, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 6'd32, 1'b1, 6'd63, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 6'd1,  1'b1, 6'd1,  1'b1, 1'b0};

    idle_inputs();
    #1 rst = 1'b1;
    #1;
    check("reset_state",
          256'({avl_read, avl_write, avl_burstcount, wr_waitrequest, rd_waitrequest, err_spurious_rdv}),
          256'({1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0}));

    // Grant decision table from IDLE.
    for (int v = 0; v < 12; v++) begin
      do_reset();
      wr_write = tbl[v].wr; wr_burstcount = tbl[v].wbc; wr_wdata = rand256();
      rd_read = tbl[v].rd; rd_burstcount = tbl[v].rbc;
      to_neg();
      chk_b($sformatf("tbl%0d_idle_rd", v), avl_read, 1'b0);
      chk_b($sformatf("tbl%0d_idle_wr", v), avl_write, 1'b0);
      to_pos();
      to_neg();
      chk_b($sformatf("tbl%0d_avl_read", v), avl_read, tbl[v].ex_rd);
      chk_b($sformatf("tbl%0d_avl_write", v), avl_write, tbl[v].ex_wr);
      chk_b($sformatf("tbl%0d_wr_wait", v), wr_waitrequest, !tbl[v].ex_wr);
      chk_b($sformatf("tbl%0d_rd_wait", v), rd_waitrequest, !tbl[v].ex_rd);
      to_pos();
    end

    // Write-only 32-beat burst without stalls.
    do_reset();
    wr_addr = 28'h0abcde0; wr_burstcount = 6'd32; wr_write = 1'b1;
    for (int i = 0; i < 34; i++) begin
      wr_wdata = rand256();
      if (i >= 33) wr_write = 1'b0;
      to_neg();
      chk_b($sformatf("t1_avl_write_c%0d", i), avl_write, (i >= 1 && i <= 32));
      chk_b($sformatf("t1_wr_wait_c%0d", i), wr_waitrequest, !(i >= 1 && i <= 32));
      to_pos();
    end

    // Simultaneous requests: read first, write after read accept.
    do_reset();
    rd_read = 1'b1; rd_burstcount = 6'd8; rd_addr = 28'h0000123;
    wr_write = 1'b1; wr_burstcount = 6'd4; wr_addr = 28'h0000456;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rd_read = 1'b0;
      wr_wdata = rand256();
      to_neg();
      chk_b($sformatf("t2_avl_read_c%0d", i), avl_read, (i == 1));
      chk_b($sformatf("t2_avl_write_c%0d", i), avl_write, (i >= 3 && i <= 6));
      to_pos();
    end

    // Outstanding cap: 2 x 32 in flight blocks a third read until one beat returns.
    do_reset();
    rd_read = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rd_burstcount = (i < 4) ? 6'd32 : 6'd1;
      avl_readdatavalid = (i == 10);
      avl_rdata = rand256();
      to_neg();
      chk_b($sformatf("t3_avl_read_c%0d", i), avl_read, (i == 1 || i == 3 || i == 12));
      to_pos();
    end

    // Write starvation guard under a continuous read stream.
    do_reset();
    rd_read = 1'b1; rd_burstcount = 6'd1;
    wr_write = 1'b1; wr_burstcount = 6'd4;
    for (int i = 0; i < 300; i++) begin
      avl_readdatavalid = (m_out > 0);
      avl_rdata = rand256();
      wr_wdata = rand256();
      to_neg();
      if (i < 257) chk_b($sformatf("t4_write_held_c%0d", i), avl_write, 1'b0);
      if (i == 257) chk_b("t4_write_granted", avl_write, 1'b1);
      to_pos();
    end

    // Accept and return beat in the same cycle: 5 + 4 - 1 = 8 outstanding.
    do_reset();
    rd_read = 1'b1;
    for (int i = 0; i < 13; i++) begin
      rd_burstcount = (i < 2) ? 6'd5 : (i < 4) ? 6'd4 : (i < 6) ? 6'd32 : (i < 11) ? 6'd25 : 6'd24;
      avl_readdatavalid = (i == 3);
      to_neg();
      chk_b($sformatf("t5_avl_read_c%0d", i), avl_read, (i == 1 || i == 3 || i == 5 || i == 12));
      to_pos();
    end

    // Reset during beat 10 of 32, then a spurious return.
    do_reset();
    wr_burstcount = 6'd32; wr_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_wdata = rand256();
      to_pos();
    end
    chk_b("t6_in_burst", avl_write, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_reset_outputs",
          256'({avl_read, avl_write, avl_burstcount, avl_addr, wr_waitrequest, rd_waitrequest, err_spurious_rdv}),
          256'({1'b0, 1'b0, 6'd0, 28'd0, 1'b1, 1'b1, 1'b0}));
    to_neg();
    to_pos();
    rst = 1'b0;
    wr_write = 1'b0;
    avl_readdatavalid = 1'b1;
    avl_rdata = rand256();
    to_neg();
    chk_b("t6_rdv_forwarded", rd_readdatavalid, 1'b1);
    chk_b("t6_err_before", err_spurious_rdv, 1'b0);
    to_pos();
    avl_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk_b($sformatf("t6_err_sticky_c%0d", i), err_spurious_rdv, 1'b1);
      to_pos();
    end

    // Randomized traffic scored by the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      wr_write = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 19))
        0:       wr_burstcount = 6'd0;
        1:       wr_burstcount = 6'($urandom_range(33, 63));
        default: wr_burstcount = 6'($urandom_range(1, 12));
      endcase
      wr_addr = 28'($urandom);
      wr_wdata = rand256();
      rd_read = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 19))
        0:       rd_burstcount = 6'd0;
        1:       rd_burstcount = 6'($urandom_range(33, 63));
        default: rd_burstcount = 6'($urandom_range(1, 32));
      endcase
      rd_addr = 28'($urandom);
      avl_waitrequest = ($urandom_range(0, 99) < 25);
      avl_readdatavalid = (m_out > 0) && ($urandom_range(0, 1) == 1);
      avl_rdata = rand256();
      to_neg();
      to_pos();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
